// File: rtl/memory_stage_pipe.sv
// memory_stage_pipe
//   MEM stage of the 5-stage RV32I core plus the MEM/WB pipeline register.
//   Holds the data memory and performs B/H/W loads and stores chosen by
//   funct3. Each memory op can take MEM_LATENCY extra wait cycles. During
//   those cycles stallM holds the upstream stages and the WB register is
//   filled with bubbles.
//
//   Optional feature: define MISALIGN_TRAP_EN to add misalignW. When it is
//   defined, misaligned H/W accesses are suppressed and flagged. When it is
//   undefined, the address is forced to natural alignment.
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     validM .. WriteDataM   MEM-stage control/data from EX/MEM
//     stallM              hold IF..MEM (MEM inputs must stay stable)
//     validW .. ReadDataW registered writeback values
//     misalignW           misaligned access flag (MISALIGN_TRAP_EN only)
//
//   Byte-lane logic assumes XLEN == 32. Wider XLEN is kept only for the
//   register and mux paths.
module memory_stage_pipe #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int MEM_LATENCY = 0,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validM,
  input  logic              flushM,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              MemReadM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        funct3M,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [XLEN-1:0]   ALU_ResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  output logic              stallM,
  output logic              validW,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [REG_AW-1:0] RD_W,
  output logic [XLEN-1:0]   PCPlus4W,
  output logic [XLEN-1:0]   ALU_ResultW,
  output logic [XLEN-1:0]   ReadDataW
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalignW
`endif
);

  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              stall, capture, live, mem_op, mis, commit;
  logic [AW-1:0]     widx;
  logic [XLEN-1:0]   rword, ldata, wdata;
  logic [3:0]        be;
  logic [7:0]        lbyte;
  logic [15:0]       lhalf;
  logic [XLEN-1:0]   mem [DEPTH_WORDS];

  assign live   = validM & ~flushM;
  assign mem_op = live & (MemReadM | MemWriteM);
  // Upper address bits are dropped, so addresses wrap modulo the array size.
  assign widx   = ALU_ResultM[AW+1:2];

`ifdef MISALIGN_TRAP_EN
  assign mis = mem_op & (((funct3M[1:0] == 2'b01) & ALU_ResultM[0]) |
                         ((funct3M[1:0] == 2'b10) & (ALU_ResultM[1:0] != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  // A misaligned access is resolved in IDLE without any wait cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && LAT != 3'd0 && !mis) begin
          state_nxt = WAIT;
          cnt_nxt   = 3'd1;
          stall     = 1'b1;
        end else begin
          capture = 1'b1;
        end
      end
      WAIT: begin
        if (flushM) begin
          // Abort: W gets a bubble (capture stays 0) and the store is dropped.
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else if (cnt < LAT) begin
          cnt_nxt = cnt + 3'd1;
          stall   = 1'b1;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
          capture   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stallM = stall & ~rst;
  assign commit = capture & mem_op & MemWriteM & ~mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Store lane enables. Data is replicated so the selected lane(s) see it.
  // Ignoring the low address bits gives natural alignment for H/W.
  always_comb begin
    case (funct3M[1:0])
      2'b00:   begin be = 4'b0001 << ALU_ResultM[1:0];
                     wdata = {4{WriteDataM[7:0]}}; end
      2'b01:   begin be = ALU_ResultM[1] ? 4'b1100 : 4'b0011;
                     wdata = {2{WriteDataM[15:0]}}; end
      default: begin be = 4'b1111; wdata = WriteDataM; end
    endcase
  end

  // Memory contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (commit && !rst)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
  end

  assign rword = mem[widx];
  assign lbyte = rword[{ALU_ResultM[1:0], 3'b000} +: 8];
  assign lhalf = rword[{ALU_ResultM[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3M[1:0])
      2'b00:   ldata = funct3M[2] ? {{(XLEN-8){1'b0}}, lbyte}
                                  : {{(XLEN-8){lbyte[7]}}, lbyte};
      2'b01:   ldata = funct3M[2] ? {{(XLEN-16){1'b0}}, lhalf}
                                  : {{(XLEN-16){lhalf[15]}}, lhalf};
      default: ldata = rword;
    endcase
  end

  // The WB register loads a bubble unless a live instruction completes this cycle.
  always_ff @(posedge clk) begin
    if (rst || !(capture && live)) begin
      validW      <= 1'b0;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
`ifdef MISALIGN_TRAP_EN
      misalignW   <= 1'b0;
`endif
    end else begin
      validW      <= 1'b1;
      RegWriteW   <= RegWriteM & ~mis;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= (MemReadM && !mis) ? ldata : '0;
`ifdef MISALIGN_TRAP_EN
      misalignW   <= mis;
`endif
    end
  end

endmodule

// File: tb/tb_memory_stage_pipe.sv
module tb_memory_stage_pipe;
  localparam int LAT = 3;
`ifdef MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_JAL = 3;

  typedef struct packed {
    logic        validM, flushM, RegWriteM, MemWriteM, MemReadM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
  } in_t;

  typedef struct packed {
    logic        validW, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
    logic        misalignW;
  } out_t;

  typedef struct { in_t i; out_t e; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  in_t  in0 = '0;
  in_t  in1 = '0;
  out_t out0, out1;
  logic s0, vw0, rw0, mw0, s1, vw1, rw1, mw1;
  logic [1:0]  rs0, rs1;
  logic [4:0]  rd0, rd1;
  logic [31:0] pc0, al0, dt0, pc1, al1, dt1;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural byte-addressed memory image per DUT (4096 bytes each)
  logic [7:0] bm [2][4096];

  memory_stage_pipe #(.MEM_LATENCY(0)) u_d0 (
    .clk(clk), .rst(rst), .validM(in0.validM), .flushM(in0.flushM),
    .RegWriteM(in0.RegWriteM), .MemWriteM(in0.MemWriteM), .MemReadM(in0.MemReadM),
    .ResultSrcM(in0.ResultSrcM), .funct3M(in0.funct3M), .RD_M(in0.RD_M),
    .PCPlus4M(in0.PCPlus4M), .ALU_ResultM(in0.ALU_ResultM), .WriteDataM(in0.WriteDataM),
    .stallM(s0), .validW(vw0), .RegWriteW(rw0), .ResultSrcW(rs0), .RD_W(rd0),
    .PCPlus4W(pc0), .ALU_ResultW(al0), .ReadDataW(dt0)
`ifdef MISALIGN_TRAP_EN
    , .misalignW(mw0)
`endif
  );

  memory_stage_pipe #(.MEM_LATENCY(LAT)) u_d1 (
    .clk(clk), .rst(rst), .validM(in1.validM), .flushM(in1.flushM),
    .RegWriteM(in1.RegWriteM), .MemWriteM(in1.MemWriteM), .MemReadM(in1.MemReadM),
    .ResultSrcM(in1.ResultSrcM), .funct3M(in1.funct3M), .RD_M(in1.RD_M),
    .PCPlus4M(in1.PCPlus4M), .ALU_ResultM(in1.ALU_ResultM), .WriteDataM(in1.WriteDataM),
    .stallM(s1), .validW(vw1), .RegWriteW(rw1), .ResultSrcW(rs1), .RD_W(rd1),
    .PCPlus4W(pc1), .ALU_ResultW(al1), .ReadDataW(dt1)
`ifdef MISALIGN_TRAP_EN
    , .misalignW(mw1)
`endif
  );

`ifndef MISALIGN_TRAP_EN
  assign mw0 = 1'b0;
  assign mw1 = 1'b0;
`endif

  assign out0 = {vw0, rw0, rs0, rd0, pc0, al0, dt0, mw0};
  assign out1 = {vw1, rw1, rs1, rd1, pc1, al1, dt1, mw1};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic stl(input int w);
    return (w == 0) ? s0 : s1;
  endfunction

  function automatic out_t rdo(input int w);
    return (w == 0) ? out0 : out1;
  endfunction

  function automatic in_t mk(input int kind, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [4:0] rd);
    in_t x;
    x = '0;
    x.validM = 1'b1; x.funct3M = f3; x.ALU_ResultM = a; x.WriteDataM = wd;
    x.RD_M = rd; x.PCPlus4M = 32'h0000_0400 + {25'd0, rd, 2'b00};
    case (kind)
      K_LD:    begin x.MemReadM = 1'b1; x.RegWriteM = 1'b1; x.ResultSrcM = 2'b01; end
      K_ST:    x.MemWriteM = 1'b1;
      K_JAL:   begin x.RegWriteM = 1'b1; x.ResultSrcM = 2'b10; end
      default: x.RegWriteM = 1'b1;
    endcase
    return x;
  endfunction

  // Expected WB record for a live, aligned instruction with the given load data
  function automatic out_t ex(input in_t x, input logic [31:0] rdat);
    out_t o;
    o = '0;
    o.validW = 1'b1; o.RegWriteW = x.RegWriteM; o.ResultSrcW = x.ResultSrcM;
    o.RD_W = x.RD_M; o.PCPlus4W = x.PCPlus4M; o.ALU_ResultW = x.ALU_ResultM;
    o.ReadDataW = rdat;
    return o;
  endfunction

  function automatic bit is_mem(input in_t x);
    return x.validM && !x.flushM && (x.MemReadM || x.MemWriteM);
  endfunction

  function automatic bit is_mis(input in_t x);
    if (!MIS_EN || !is_mem(x)) return 1'b0;
    if (x.funct3M[1:0] == 2'b01) return x.ALU_ResultM[0];
    if (x.funct3M[1:0] == 2'b10) return x.ALU_ResultM[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_val(input int w, input in_t x);
    int b;
    logic [7:0]  v8;
    logic [15:0] v16;
    b = int'(x.ALU_ResultM[11:0]);
    case (x.funct3M[1:0])
      2'b00: begin
        v8 = bm[w][b];
        return x.funct3M[2] ? {24'd0, v8} : {{24{v8[7]}}, v8};
      end
      2'b01: begin
        b = b - (b % 2);
        v16 = {bm[w][b+1], bm[w][b]};
        return x.funct3M[2] ? {16'd0, v16} : {{16{v16[15]}}, v16};
      end
      default: begin
        b = b - (b % 4);
        return {bm[w][b+3], bm[w][b+2], bm[w][b+1], bm[w][b]};
      end
    endcase
  endfunction

  function automatic out_t model_wb(input int w, input in_t x);
    out_t o;
    bit m;
    if (!x.validM || x.flushM) return '0;
    m = is_mis(x);
    o = ex(x, (x.MemReadM && !m) ? load_val(w, x) : 32'd0);
    o.RegWriteW = x.RegWriteM && !m;
    o.misalignW = m;
    return o;
  endfunction

  task automatic model_commit(input int w, input in_t x);
    int b;
    if (!is_mem(x) || !x.MemWriteM || is_mis(x)) return;
    b = int'(x.ALU_ResultM[11:0]);
    case (x.funct3M[1:0])
      2'b00: bm[w][b] = x.WriteDataM[7:0];
      2'b01: begin
        b = b - (b % 2);
        bm[w][b] = x.WriteDataM[7:0]; bm[w][b+1] = x.WriteDataM[15:8];
      end
      default: begin
        b = b - (b % 4);
        for (int k = 0; k < 4; k++) bm[w][b+k] = x.WriteDataM[8*k +: 8];
      end
    endcase
  endtask

  // Issue one instruction, check every stall/bubble cycle, then the WB capture.
  task automatic do_op(input int w, input in_t op, output out_t got);
    out_t exp;
    int   lat;
    lat = (w == 0) ? 0 : LAT;
    exp = model_wb(w, op);
    @(negedge clk);
    if (w == 0) in0 = op; else in1 = op;
    if (is_mem(op) && !is_mis(op)) begin
      for (int k = 0; k < lat; k++) begin
        #1 chk("stall_hi", stl(w), 1'b1);
        @(posedge clk);
        #1 chk("bubble", rdo(w), '0);
        @(negedge clk);
      end
    end
    #1 chk("stall_lo", stl(w), 1'b0);
    @(posedge clk);
    #1 got = rdo(w);
    chk("wb", got, exp);
    model_commit(w, op);
    @(negedge clk);
    if (w == 0) in0 = '0; else in1 = '0;
  endtask

  vec_t tbl[16];
  out_t got;
  in_t  op;
  logic [2:0] ld_f3 [5];
  logic [31:0] a;

  initial begin
    tbl[0]  = '{mk(K_ST, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0), '0};
    tbl[1]  = '{mk(K_LD, 3'b010, 32'h10, 32'h0, 5'd1), '0};
    tbl[2]  = '{mk(K_ST, 3'b000, 32'h12, 32'h000000EF, 5'd0), '0};
    tbl[3]  = '{mk(K_ST, 3'b000, 32'h13, 32'h00000080, 5'd0), '0};
    tbl[4]  = '{mk(K_LD, 3'b000, 32'h13, 32'h0, 5'd2), '0};
    tbl[5]  = '{mk(K_LD, 3'b100, 32'h13, 32'h0, 5'd3), '0};
    tbl[6]  = '{mk(K_LD, 3'b101, 32'h12, 32'h0, 5'd4), '0};
    tbl[7]  = '{mk(K_LD, 3'b001, 32'h12, 32'h0, 5'd5), '0};
    tbl[8]  = '{mk(K_LD, 3'b010, 32'h10, 32'h0, 5'd6), '0};
    tbl[9]  = '{mk(K_ALU, 3'b000, 32'h1234, 32'h0, 5'd7), '0};
    tbl[10] = '{mk(K_ST, 3'b001, 32'h16, 32'h11119ABC, 5'd0), '0};
    tbl[11] = '{mk(K_LD, 3'b001, 32'h16, 32'h0, 5'd8), '0};
    tbl[12] = '{mk(K_LD, 3'b100, 32'h17, 32'h0, 5'd9), '0};
    tbl[13] = '{mk(K_ST, 3'b010, 32'h10, 32'h0, 5'd0), '0};
    tbl[13].i.validM = 1'b0;
    tbl[14] = '{mk(K_ST, 3'b010, 32'h10, 32'h0, 5'd0), '0};
    tbl[14].i.flushM = 1'b1;
    tbl[15] = '{mk(K_LD, 3'b010, 32'h10, 32'h0, 5'd10), '0};
    tbl[0].e  = ex(tbl[0].i,  32'h0);
    tbl[1].e  = ex(tbl[1].i,  32'hDEADBEEF);
    tbl[2].e  = ex(tbl[2].i,  32'h0);
    tbl[3].e  = ex(tbl[3].i,  32'h0);
    tbl[4].e  = ex(tbl[4].i,  32'hFFFFFF80);
    tbl[5].e  = ex(tbl[5].i,  32'h00000080);
    tbl[6].e  = ex(tbl[6].i,  32'h000080EF);
    tbl[7].e  = ex(tbl[7].i,  32'hFFFF80EF);
    tbl[8].e  = ex(tbl[8].i,  32'h80EFBEEF);
    tbl[9].e  = ex(tbl[9].i,  32'h0);
    tbl[10].e = ex(tbl[10].i, 32'h0);
    tbl[11].e = ex(tbl[11].i, 32'hFFFF9ABC);
    tbl[12].e = ex(tbl[12].i, 32'h0000009A);
    tbl[15].e = ex(tbl[15].i, 32'h80EFBEEF);
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    // Reset: hold a live ALU op on the inputs so a missing reset would show up
    in0 = mk(K_ALU, 3'b000, 32'h55, 32'h0, 5'd3);
    repeat (3) @(posedge clk);
    #1 chk("rst_out0", out0, '0);
    chk("rst_out1", out1, '0);
    chk("rst_stall1", s1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in0 = '0;

    // Give the low 64 bytes of both memories defined contents
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 16; k++)
        do_op(w, mk(K_ST, 3'b010, 32'(k * 4), $urandom, 5'd0), got);

    // Directed vectors on the single-cycle instance
    for (int k = 0; k < 16; k++) begin
      do_op(0, tbl[k].i, got);
      chk($sformatf("tbl%0d", k), got, tbl[k].e);
    end

    // Multi-cycle load, then a back-to-back ALU op that must not stall
    do_op(1, mk(K_LD, 3'b010, 32'h8, 32'h0, 5'd11), got);
    do_op(1, mk(K_ALU, 3'b000, 32'h77, 32'h0, 5'd12), got);
    chk("alu_after_ld_valid", got.validW, 1'b1);

    // Flush during WAIT: bubble to W and the store must be dropped
    @(negedge clk);
    in1 = mk(K_ST, 3'b010, 32'h20, 32'h12345678, 5'd0);
    #1 chk("flush_stall0", s1, 1'b1);
    @(posedge clk);
    #1 chk("flush_bub0", out1, '0);
    @(negedge clk);
    in1.flushM = 1'b1;
    @(posedge clk);
    #1 chk("flush_bub1", out1, '0);
    @(negedge clk);
    in1 = '0;
    do_op(1, mk(K_LD, 3'b010, 32'h20, 32'h0, 5'd13), got);

    // Address wrap modulo 4 KiB
    do_op(1, mk(K_ST, 3'b010, 32'h1000, 32'hA5A5A5A5, 5'd0), got);
    do_op(1, mk(K_LD, 3'b010, 32'h0, 32'h0, 5'd14), got);
    chk("wrap", got.ReadDataW, 32'hA5A5A5A5);

    // Reset in the middle of WAIT: outputs zeroed, pending store dropped
    @(negedge clk);
    in1 = mk(K_ST, 3'b010, 32'h24, 32'hFEEDFACE, 5'd0);
    @(posedge clk);
    @(negedge clk);
    in0 = mk(K_JAL, 3'b000, 32'h99, 32'h0, 5'd15);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("rstw_out1", out1, '0);
    chk("rstw_out0", out0, '0);
    chk("rstw_stall", s1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in0 = '0;
    in1 = '0;
    do_op(1, mk(K_LD, 3'b010, 32'h24, 32'h0, 5'd16), got);

`ifdef MISALIGN_TRAP_EN
    do_op(1, mk(K_LD, 3'b010, 32'h22, 32'h0, 5'd17), got);
    chk("mis_flag", got.misalignW, 1'b1);
    chk("mis_regwr", got.RegWriteW, 1'b0);
    do_op(1, mk(K_ST, 3'b001, 32'h21, 32'h0000BEEF, 5'd0), got);
    chk("mis_st_flag", got.misalignW, 1'b1);
    do_op(1, mk(K_LD, 3'b010, 32'h20, 32'h0, 5'd18), got);
`endif

    // Random traffic against the byte-level model
    for (int n = 0; n < 200; n++) begin
      int w, kind;
      w    = $urandom_range(0, 1);
      kind = $urandom_range(0, 3);
      a    = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom << 12);
      op = mk(kind, (kind == K_ST) ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)],
              a, $urandom, 5'($urandom_range(0, 31)));
      op.validM = ($urandom_range(0, 9) != 0);
      op.flushM = ($urandom_range(0, 9) == 0);
      do_op(w, op, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
